nanodac_arbiter: RTL and testbench

Shares the single nanoDAC SPI frame path between a periodic pixel requester (video/black-level codes at the CCD sample rate) and a low-rate configuration requester (DAC command words). Formats the 24-bit frame, drives the SPI master's `in_data`/`in_ena`, and tracks frame completion from its busy flag. Pixel traffic has priority, but configuration traffic is never starved. Sits between the sample-timing generator and `spi_master_reg`, replacing the direct `spi_ena`/`spi_data` drive.

---
 rtl/nanodac_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_nanodac_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanodac_arbiter.sv
// nanodac_arbiter
// Shares the nanoDAC SPI frame path between a periodic pixel requester and a
// low-rate configuration requester. Pixel traffic wins by default, but a
// pending configuration word is forced through after MAX_DEFER pixel grants.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | arbitrate between pending slots, load spi_data on a grant
// ST_ISSUE     | spi_ena high for this single cycle
// ST_WAIT_BUSY | wait for the SPI master to raise busy, bounded by BUSY_TO
// ST_WAIT_DONE | wait for busy to fall, then ack the granted requester
// ST_SETTLE    | SETTLE idle cycles before the next grant
module nanodac_arbiter #(
    parameter int MAX_DEFER = 4,
    parameter int SETTLE    = 2,
    parameter int BUSY_TO   = 8
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        pix_req,
    input  logic [15:0] pix_data,
    output logic        pix_ack,
    output logic        pix_drop,
    output logic [7:0]  drop_count,
    input  logic        cfg_req,
    input  logic [3:0]  cfg_cmd,
    input  logic [15:0] cfg_data,
    output logic        cfg_ack,
    output logic [23:0] spi_data,
    output logic        spi_ena,
    input  logic        spi_busy,
    output logic        err
);

    localparam int TMR_MAX = (BUSY_TO > SETTLE) ? BUSY_TO : ((SETTLE > 1) ? SETTLE : 1);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DEF_W   = $clog2(MAX_DEFER + 1);

    // The shared timer is a down-counter; ISSUE counts as the first busy-wait
    // cycle so that the timeout lands exactly BUSY_TO cycles after spi_ena.
    localparam logic [TMR_W-1:0] BUSY_LOAD   = TMR_W'((BUSY_TO > 0) ? BUSY_TO - 1 : 0);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [DEF_W-1:0] DEFER_MAX   = DEF_W'(MAX_DEFER);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_SETTLE
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic               owner_cfg;

    logic               pix_vld;
    logic [15:0]        pix_buf;
    logic               cfg_vld;
    logic [3:0]         cfg_cmd_buf;
    logic [15:0]        cfg_data_buf;
    logic [DEF_W-1:0]   defer;

    logic               gnt_cfg;
    logic               gnt_pix;

    // Arbitration: config goes first when the pixel side has had its quota
    // or has nothing to send.
    always_comb begin
        gnt_cfg = 1'b0;
        gnt_pix = 1'b0;
        if (state == ST_IDLE) begin
            gnt_cfg = cfg_vld && ((defer == DEFER_MAX) || !pix_vld);
            gnt_pix = pix_vld && !gnt_cfg;
        end
    end

    // spi_ena is a pure state decode so it can never glitch or stretch.
    assign spi_ena = (state == ST_ISSUE);

    // Pixel slot: a new request overwrites, counted as a drop unless the old
    // word is leaving through a grant in the same cycle.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pix_vld    <= 1'b0;
            pix_buf    <= '0;
            pix_drop   <= 1'b0;
            drop_count <= '0;
        end else begin
            pix_drop <= pix_req && pix_vld && !gnt_pix;
            if (pix_req && pix_vld && !gnt_pix && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            if (pix_req) begin
                pix_vld <= 1'b1;
                pix_buf <= pix_data;
            end else if (gnt_pix) begin
                pix_vld <= 1'b0;
            end
        end
    end

    // Config slot and its deferral counter; requests into a full slot are lost.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cfg_vld      <= 1'b0;
            cfg_cmd_buf  <= '0;
            cfg_data_buf <= '0;
            defer        <= '0;
        end else begin
            if (cfg_req && !cfg_vld) begin
                cfg_vld      <= 1'b1;
                cfg_cmd_buf  <= cfg_cmd;
                cfg_data_buf <= cfg_data;
            end else if (gnt_cfg) begin
                cfg_vld <= 1'b0;
            end
            if (!cfg_vld || gnt_cfg) begin
                defer <= '0;
            end else if (gnt_pix) begin
                defer <= defer + DEF_W'(1);
            end
        end
    end

    // Frame sequencer with registered frame, acks and sticky timeout flag.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            owner_cfg <= 1'b0;
            spi_data  <= '0;
            pix_ack   <= 1'b0;
            cfg_ack   <= 1'b0;
            err       <= 1'b0;
        end else begin
            pix_ack <= 1'b0;
            cfg_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_cfg) begin
                        spi_data  <= {cfg_cmd_buf, cfg_data_buf, 4'b0000};
                        owner_cfg <= 1'b1;
                        tmr       <= BUSY_LOAD;
                        state     <= ST_ISSUE;
                    end else if (gnt_pix) begin
                        spi_data  <= {4'b0011, pix_buf, 4'b0000};
                        owner_cfg <= 1'b0;
                        tmr       <= BUSY_LOAD;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (tmr != '0) begin
                        tmr <= tmr - TMR_W'(1);
                    end
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (spi_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmr == '0) begin
                        err <= 1'b1;
                        if (SETTLE == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            tmr   <= SETTLE_LOAD;
                            state <= ST_SETTLE;
                        end
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!spi_busy) begin
                        pix_ack <= !owner_cfg;
                        cfg_ack <= owner_cfg;
                        if (SETTLE == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            tmr   <= SETTLE_LOAD;
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (tmr == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nanodac_arbiter.sv
// Bench for nanodac_arbiter: a transaction-level model predicts every frame,
// ack and drop (with the cycle it must appear in) and queues it; a monitor on
// the falling edge pops and compares whenever the DUT presents an output.
`timescale 1ns/1ps
module tb_nanodac_arbiter;

    localparam int MAX_DEFER = 4;
    localparam int SETTLE    = 2;
    localparam int BUSY_TO   = 8;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_req = 1'b0;
    logic [15:0] pix_data = '0;
    logic        pix_ack;
    logic        pix_drop;
    logic [7:0]  drop_count;
    logic        cfg_req = 1'b0;
    logic [3:0]  cfg_cmd = '0;
    logic [15:0] cfg_data = '0;
    logic        cfg_ack;
    logic [23:0] spi_data;
    logic        spi_ena;
    logic        spi_busy = 1'b0;
    logic        err;

    nanodac_arbiter #(.MAX_DEFER(MAX_DEFER), .SETTLE(SETTLE), .BUSY_TO(BUSY_TO)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .pix_req(pix_req), .pix_data(pix_data), .pix_ack(pix_ack),
        .pix_drop(pix_drop), .drop_count(drop_count),
        .cfg_req(cfg_req), .cfg_cmd(cfg_cmd), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
        .spi_data(spi_data), .spi_ena(spi_ena), .spi_busy(spi_busy), .err(err)
    );

    always #125 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [23:0] frame; } iss_t;
    typedef struct { int cyc; bit is_cfg; } ack_t;
    typedef struct { int cyc; int cnt; } drop_t;

    iss_t  iss_q[$];
    ack_t  ack_q[$];
    drop_t drop_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit          m_pix_vld = 0;
    logic [15:0] m_pix_dat = '0;
    bit          m_cfg_vld = 0;
    logic [3:0]  m_cfg_cmd = '0;
    logic [15:0] m_cfg_dat = '0;
    int          m_defer = 0;
    int          m_drops = 0;
    bit          m_err = 0;
    int          m_err_at = 0;
    int          idle_from = 0;
    int          cfg_free_at = 0;

    // SPI master model: busy rises cur_L cycles after spi_ena, lasts cur_B
    int cur_L = 1, cur_B = 1;
    int busy_lo = 0, busy_hi = 0;
    int busy_mode = 0;   // 0 random, 1 fixed, 2 never busy
    int fix_L = 1, fix_B = 30;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic flag_missing(input string name, input int exp_cyc);
        n_checks++;
        $display("FAIL %s: output absent, expected at cycle %0d (now %0d)", name, exp_cyc, cyc);
    endtask

    // One clock of stimulus; also advances the model by one cycle.
    task automatic step(input bit p_req, input logic [15:0] p_dat,
                        input bit c_want, input logic [3:0] c_cmd, input logic [15:0] c_dat);
        int c, t, l, b;
        bit take_cfg, cfg_pre, c_req;
        logic [23:0] fr;
        @(posedge sys_clk);
        #1;
        c = cyc;
        if (spi_ena) begin
            busy_lo = c + cur_L;
            busy_hi = c + cur_L + cur_B;
        end
        spi_busy = (c >= busy_lo) && (c < busy_hi);
        cfg_pre = m_cfg_vld;
        c_req = c_want && !m_cfg_vld && (c >= cfg_free_at);

        if (c >= idle_from && (m_pix_vld || m_cfg_vld)) begin
            take_cfg = m_cfg_vld && (m_defer >= MAX_DEFER || !m_pix_vld);
            if (take_cfg) begin
                fr = {m_cfg_cmd, m_cfg_dat, 4'h0};
                m_cfg_vld = 0;
                m_defer = 0;
            end else begin
                fr = {4'h3, m_pix_dat, 4'h0};
                m_pix_vld = 0;
                if (m_cfg_vld) m_defer++;
            end
            t = c + 1;
            if (busy_mode == 1) begin
                l = fix_L; b = fix_B;
            end else if (busy_mode == 2 || $urandom_range(0, 11) == 0) begin
                l = 1; b = 0;
            end else begin
                l = $urandom_range(1, 4); b = $urandom_range(1, 12);
            end
            cur_L = l;
            cur_B = b;
            iss_q.push_back('{t, fr});
            if (b == 0) begin
                if (!m_err) begin
                    m_err = 1;
                    m_err_at = t + BUSY_TO;
                end
                idle_from = t + BUSY_TO + SETTLE;
            end else begin
                ack_q.push_back('{t + l + b + 1, take_cfg});
                idle_from = t + l + b + 1 + SETTLE;
            end
            if (take_cfg) cfg_free_at = idle_from;
        end

        if (p_req) begin
            if (m_pix_vld) begin
                if (m_drops < 255) m_drops++;
                drop_q.push_back('{c + 1, m_drops});
            end
            m_pix_vld = 1;
            m_pix_dat = p_dat;
        end
        if (c_req && !cfg_pre) begin
            m_cfg_vld = 1;
            m_cfg_cmd = c_cmd;
            m_cfg_dat = c_dat;
        end

        pix_req  = p_req;
        pix_data = p_dat;
        cfg_req  = c_req;
        cfg_cmd  = c_cmd;
        cfg_data = c_dat;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 4'h0, 16'h0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((iss_q.size() != 0 || ack_q.size() != 0 || drop_q.size() != 0 ||
                m_pix_vld || m_cfg_vld || cyc < idle_from + 2) && guard < 3000) begin
            idle(1);
            guard++;
        end
        if (guard >= 3000) flag_missing("drain_timeout", idle_from);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_spi_data"}, spi_data, 0);
        check({tag, "_spi_ena"}, spi_ena, 0);
        check({tag, "_pix_ack"}, pix_ack, 0);
        check({tag, "_cfg_ack"}, cfg_ack, 0);
        check({tag, "_pix_drop"}, pix_drop, 0);
        check({tag, "_drop_count"}, drop_count, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic reset_now();
        @(posedge sys_clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("rst_mid");
        iss_q.delete();
        ack_q.delete();
        drop_q.delete();
        m_pix_vld = 0; m_cfg_vld = 0; m_defer = 0; m_drops = 0;
        m_err = 0; m_err_at = 0; cfg_free_at = 0;
        busy_lo = 0; busy_hi = 0; spi_busy = 1'b0;
        pix_req = 1'b0; cfg_req = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        rst = 1'b0;
        idle_from = cyc;
    endtask

    iss_t  ei;
    ack_t  ea;
    drop_t ed;

    // Monitor: compare each DUT output event against the head of its queue.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (spi_ena) begin
                if (iss_q.size() == 0) flag_missing("spi_ena_unexpected_none_queued", -1);
                else begin
                    ei = iss_q.pop_front();
                    check("issue_cycle", cyc, ei.cyc);
                    check("spi_data", spi_data, ei.frame);
                end
            end else if (iss_q.size() != 0 && iss_q[0].cyc <= cyc) begin
                flag_missing("spi_ena", iss_q[0].cyc);
                ei = iss_q.pop_front();
            end

            if (pix_ack || cfg_ack) begin
                if (ack_q.size() == 0) flag_missing("ack_unexpected_none_queued", -1);
                else begin
                    ea = ack_q.pop_front();
                    check("ack_cycle", cyc, ea.cyc);
                    check("ack_kind", {30'b0, pix_ack, cfg_ack}, ea.is_cfg ? 32'd1 : 32'd2);
                end
            end else if (ack_q.size() != 0 && ack_q[0].cyc <= cyc) begin
                flag_missing("ack", ack_q[0].cyc);
                ea = ack_q.pop_front();
            end

            if (pix_drop) begin
                if (drop_q.size() == 0) flag_missing("pix_drop_unexpected_none_queued", -1);
                else begin
                    ed = drop_q.pop_front();
                    check("drop_cycle", cyc, ed.cyc);
                    check("drop_count", drop_count, ed.cnt);
                end
            end else if (drop_q.size() != 0 && drop_q[0].cyc <= cyc) begin
                flag_missing("pix_drop", drop_q[0].cyc);
                ed = drop_q.pop_front();
            end

            check("err", err, (m_err && cyc >= m_err_at) ? 32'd1 : 32'd0);
        end
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_values("rst_init");
        rst = 1'b0;
        idle_from = cyc;

        // single pixel, 30-cycle busy
        busy_mode = 1; fix_L = 1; fix_B = 30;
        idle(10);
        step(1'b1, 16'h1000, 1'b0, 4'h0, 16'h0);
        drain();

        // overrun while a frame sits in WAIT_DONE
        fix_B = 20;
        step(1'b1, 16'h1234, 1'b0, 4'h0, 16'h0);
        idle(6);
        step(1'b1, 16'hAAAA, 1'b0, 4'h0, 16'h0);
        step(1'b1, 16'h5555, 1'b0, 4'h0, 16'h0);
        drain();

        // starvation guard: pixels requested back to back with config pending
        fix_B = 3;
        step(1'b1, 16'h0100, 1'b1, 4'h4, 16'h0001);
        for (int i = 0; i < 60; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 4'h0, 16'h0);
        drain();

        // busy timeout; the second request lands on the grant cycle of the first
        busy_mode = 2;
        step(1'b1, 16'h0777, 1'b0, 4'h0, 16'h0);
        step(1'b1, 16'h0888, 1'b0, 4'h0, 16'h0);
        busy_mode = 1; fix_B = 4;
        drain();

        // randomized traffic
        busy_mode = 0;
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 5) == 0, 16'($urandom), $urandom_range(0, 14) == 0,
                 4'($urandom), 16'($urandom));
        drain();

        // reset during WAIT_DONE with both slots pending
        busy_mode = 1; fix_L = 1; fix_B = 30;
        step(1'b1, 16'h0ABC, 1'b0, 4'h0, 16'h0);
        idle(6);
        step(1'b1, 16'h0DEF, 1'b1, 4'h9, 16'h1357);
        idle(1);
        reset_now();
        idle(20);

        // drop counter saturation
        fix_B = 400;
        for (int i = 0; i < 320; i++) step(1'b1, 16'(i), 1'b0, 4'h0, 16'h0);
        fix_B = 5;
        drain();
        check("drop_count_saturated", drop_count, 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
